bus_arbiter_n: RTL and testbench

- Parametrised N-client successor to the 4-client bus arbiter. Multiplexes N request/acknowledge clients onto one server port, such as the RAM.
- Arbitration is strict priority or round robin, selected by parameter.
- An optional watchdog aborts transfers the server never acknowledges.
- Sits between the client array and the single memory server in system-level benches and designs.

---
 rtl/bus_arbiter_n.sv | 134 +++++++++++++
 tb/tb_bus_arbiter_n.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_n.sv
// N-client request/acknowledge arbiter onto a single server port (strict priority or round robin).
// Define ARB_TIMEOUT_EN to add a watchdog that aborts transfers the server never acknowledges.
module bus_arbiter_n #(
    parameter int DATA_WIDTH                    = 8,
    parameter int ADDR_WIDTH                    = 4,
    parameter int NUM_CLIENTS                   = 4,
    parameter int PRIORITY_SCHEDULING_ALGORITHM = 0,
    parameter int TIMEOUT_CYCLES                = 16,
    localparam int ID_WIDTH                     = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            client_rq,
    input  logic [NUM_CLIENTS-1:0]            client_wr_ni,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataW,
    output logic [NUM_CLIENTS-1:0]            client_ack,
    output logic [NUM_CLIENTS-1:0]            client_err,
    output logic [DATA_WIDTH-1:0]             client_dataR,
    output logic                              server_rq,
    output logic                              server_wr_ni,
    output logic [ADDR_WIDTH-1:0]             server_address,
    output logic [DATA_WIDTH-1:0]             server_dataW,
    input  logic                              server_ack,
    input  logic [DATA_WIDTH-1:0]             server_dataR,
    output logic                              grant_valid,
    output logic [ID_WIDTH-1:0]               grant_id
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t              state, state_nx;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] winner;
    logic                busy, resp, wd_hit;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0] data_arr [NUM_CLIENTS];

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_slice
        assign addr_arr[g] = client_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g] = client_dataW[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign busy = (state == BUSY);
    assign resp = (state == RESP);

    // Loops run from the far end so the nearest eligible client is written last and wins.
    always_comb begin
        int sum;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        sum    = 0;
        if (PRIORITY_SCHEDULING_ALGORITHM == 0) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (client_rq[i]) winner = ID_WIDTH'(i);
            end
        end else begin
            for (int k = NUM_CLIENTS; k >= 1; k--) begin
                sum = int'(last_grant) + k;
                if (sum >= NUM_CLIENTS) sum = sum - NUM_CLIENTS;
                if (client_rq[ID_WIDTH'(sum)]) winner = ID_WIDTH'(sum);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|client_rq) state_nx = BUSY;
            BUSY:    if (server_ack || wd_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign server_rq      = busy;
    assign grant_valid    = busy;
    assign server_wr_ni   = busy ? client_wr_ni[grant_id] : 1'b0;
    assign server_address = busy ? addr_arr[grant_id] : '0;
    assign server_dataW   = busy ? data_arr[grant_id] : '0;

    always_comb begin
        client_ack = '0;
        if (resp) client_ack[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state        <= IDLE;
            grant_id     <= '0;
            last_grant   <= ID_WIDTH'(NUM_CLIENTS - 1);
            client_dataR <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |client_rq) grant_id <= winner;
            // Writes leave the shared read-data register untouched.
            if (busy && server_ack) begin
                if (!server_wr_ni) client_dataR <= server_dataR;
            end else if (wd_hit) begin
                client_dataR <= '0;
            end
            if (resp) last_grant <= grant_id;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       err_q;

    // A server_ack in the limit cycle masks the abort.
    assign wd_hit     = busy && !server_ack && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign client_err = err_q ? client_ack : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (busy) begin
                wd_cnt <= wd_cnt + 8'd1;
                err_q  <= wd_hit;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    assign wd_hit     = 1'b0;
    assign client_err = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: strict 4-client lane 0 and round-robin 8-client lane 1, each with a RAM stub.
// Expected acks are queued at stimulus time and compared by a monitor when the DUT acks.
module tb_bus_arbiter_n;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [7:0]  rq [2];
    logic [7:0]  wr [2];
    logic [31:0] ab [2];
    logic [63:0] db [2];
    logic [7:0]  ack [2], err [2], dr [2];
    logic        s_rq [2], s_wr [2], s_ack [2], gv [2];
    logic [3:0]  s_addr [2];
    logic [7:0]  s_dw [2], s_dr [2];
    logic [2:0]  gid [2];

    logic [3:0] ack0, err0;
    logic [1:0] gid0;
    logic [7:0] ack1, err1;
    logic [2:0] gid1;

    assign ack[0] = {4'b0, ack0};
    assign err[0] = {4'b0, err0};
    assign gid[0] = {1'b0, gid0};
    assign ack[1] = ack1;
    assign err[1] = err1;
    assign gid[1] = gid1;

    bus_arbiter_n #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_CLIENTS(4),
                    .PRIORITY_SCHEDULING_ALGORITHM(0), .TIMEOUT_CYCLES(TO)) u_strict (
        .clk(clk), .reset(reset),
        .client_rq(rq[0][3:0]), .client_wr_ni(wr[0][3:0]),
        .client_address(ab[0][15:0]), .client_dataW(db[0][31:0]),
        .client_ack(ack0), .client_err(err0), .client_dataR(dr[0]),
        .server_rq(s_rq[0]), .server_wr_ni(s_wr[0]), .server_address(s_addr[0]),
        .server_dataW(s_dw[0]), .server_ack(s_ack[0]), .server_dataR(s_dr[0]),
        .grant_valid(gv[0]), .grant_id(gid0)
    );

    bus_arbiter_n #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_CLIENTS(8),
                    .PRIORITY_SCHEDULING_ALGORITHM(1), .TIMEOUT_CYCLES(TO)) u_rr (
        .clk(clk), .reset(reset),
        .client_rq(rq[1]), .client_wr_ni(wr[1]),
        .client_address(ab[1]), .client_dataW(db[1]),
        .client_ack(ack1), .client_err(err1), .client_dataR(dr[1]),
        .server_rq(s_rq[1]), .server_wr_ni(s_wr[1]), .server_address(s_addr[1]),
        .server_dataW(s_dw[1]), .server_ack(s_ack[1]), .server_dataR(s_dr[1]),
        .grant_valid(gv[1]), .grant_id(gid1)
    );

    typedef struct {
        logic [2:0] id;
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       sb0 [$];
    exp_t       sb1 [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         issued [2][8];
    int         done   [2][8];
    int         wait_n [2];
    int         wcnt   [2];
    bit         mute   [2];
    logic [7:0] mem    [2][16];
    logic [7:0] exp_dr [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_init(input int a);
        logic [3:0] x;
        x = 4'(a);
        return {x, ~x};
    endfunction

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Clients: raise rq while requests are outstanding, drop it the cycle after the ack.
    initial begin
        rq[0] = '0;
        rq[1] = '0;
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                for (int i = 0; i < 8; i++) begin
                    if (reset) begin
                        rq[l][i]   = 1'b0;
                        done[l][i] = issued[l][i];
                    end else if (ack[l][i]) begin
                        rq[l][i] = 1'b0;
                        done[l][i]++;
                    end else if (!rq[l][i] && issued[l][i] != done[l][i]) begin
                        rq[l][i] = 1'b1;
                    end
                end
            end
        end
    end

    // RAM stub: acks after wait_n[l] extra BUSY cycles, never while muted.
    initial begin
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < 16; a++) mem[l][a] = mem_init(a);
            s_ack[l] = 1'b0;
            s_dr[l]  = '0;
            wcnt[l]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (s_rq[l] && !s_ack[l] && !mute[l]) begin
                    if (wcnt[l] >= wait_n[l]) begin
                        s_ack[l] = 1'b1;
                        wcnt[l]  = 0;
                        if (s_wr[l]) mem[l][s_addr[l]] = s_dw[l];
                        else         s_dr[l] = mem[l][s_addr[l]];
                    end else begin
                        wcnt[l]++;
                    end
                end else begin
                    s_ack[l] = 1'b0;
                    if (!s_rq[l]) wcnt[l] = 0;
                end
            end
        end
    end

    // Monitor: every ack must match the oldest queued expectation of its lane.
    initial forever begin
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            if (ack[l] != 0) begin
                if ((l == 0 && sb0.size() == 0) || (l == 1 && sb1.size() == 0)) begin
                    check($sformatf("l%0d_unexpected_ack", l), 32'(ack[l]), 0);
                end else begin
                    exp_t e;
                    if (l == 0) e = sb0.pop_front();
                    else        e = sb1.pop_front();
                    check($sformatf("l%0d_ack_id", l), 32'(ack[l]), 32'(8'd1 << e.id));
                    check($sformatf("l%0d_err", l), 32'(err[l]), 32'({7'd0, e.err} << e.id));
                    check($sformatf("l%0d_dataR", l), 32'(dr[l]), 32'(e.data));
                    check($sformatf("l%0d_ack_cycle", l), cyc, e.cyc);
                end
            end else if (err[l] != 0) begin
                check($sformatf("l%0d_err_without_ack", l), 32'(err[l]), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected end", cyc);
        $fatal(1);
    end

    task automatic expect_ack(input int l, input int id, input logic [7:0] data, input bit e, input int c);
        exp_t x;
        x.id   = 3'(id);
        x.data = data;
        x.err  = e;
        x.cyc  = c;
        if (l == 0) sb0.push_back(x);
        else        sb1.push_back(x);
    endtask

    task automatic expect_rd(input int l, input int id, input logic [7:0] d, input int c);
        exp_dr[l] = d;
        expect_ack(l, id, d, 1'b0, c);
    endtask

    task automatic expect_wr(input int l, input int id, input int c);
        expect_ack(l, id, exp_dr[l], 1'b0, c);
    endtask

    task automatic issue(input int l, input int i, input bit w, input logic [3:0] a,
                         input logic [7:0] d, input int times);
        wr[l][i]         = w;
        ab[l][i*4 +: 4]  = a;
        db[l][i*8 +: 8]  = d;
        issued[l][i]    += times;
    endtask

    function automatic bit clients_busy();
        bit b = (rq[0] != 0) || (rq[1] != 0);
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 8; i++)
                if (issued[l][i] != done[l][i]) b = 1'b1;
        return b;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || clients_busy()) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            check("drain_timeout", n, 0);
            sb0.delete();
            sb1.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int k0;
        for (int l = 0; l < 2; l++) begin
            wr[l]     = '0;
            ab[l]     = '0;
            db[l]     = '0;
            wait_n[l] = 1;
            mute[l]   = 1'b0;
            exp_dr[l] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("l%0d_rst_server_rq", l), 32'(s_rq[l]), 0);
            check($sformatf("l%0d_rst_ack", l), 32'(ack[l]), 0);
            check($sformatf("l%0d_rst_err", l), 32'(err[l]), 0);
            check($sformatf("l%0d_rst_grant_valid", l), 32'(gv[l]), 0);
            check($sformatf("l%0d_rst_grant_id", l), 32'(gid[l]), 0);
            check($sformatf("l%0d_rst_dataR", l), 32'(dr[l]), 0);
        end
        reset = 1'b0;
        wait_idle();

        // Strict: clients 1 and 3 together
        sync(); k0 = cyc;
        issue(0, 1, 1'b0, 4'd2, 8'h00, 1);
        issue(0, 3, 1'b0, 4'd7, 8'h00, 1);
        expect_rd(0, 1, mem_init(2), k0 + 3);
        expect_rd(0, 3, mem_init(7), k0 + 7);
        @(negedge clk);
        @(negedge clk);
        check("strict_grant_valid", 32'(gv[0]), 1);
        check("strict_grant_id", 32'(gid[0]), 1);
        check("strict_server_rq", 32'(s_rq[0]), 1);
        check("strict_server_addr", 32'(s_addr[0]), 2);
        wait_idle();

        // Write 0xA5 to 5 from client 1, read back from client 2
        sync(); k0 = cyc;
        issue(0, 1, 1'b1, 4'd5, 8'hA5, 1);
        issue(0, 2, 1'b0, 4'd5, 8'h00, 1);
        expect_wr(0, 1, k0 + 3);
        expect_rd(0, 2, 8'hA5, k0 + 7);
        @(negedge clk);
        @(negedge clk);
        check("wr_server_wr_ni", 32'(s_wr[0]), 1);
        check("wr_server_dataW", 32'(s_dw[0]), 32'h A5);
        wait_idle();

        // Round robin: clients 0..3 each request twice, continuously
        sync(); k0 = cyc;
        for (int i = 0; i < 4; i++) issue(1, i, 1'b0, 4'(8 + i), 8'h00, 2);
        for (int j = 0; j < 8; j++) expect_rd(1, j % 4, mem_init(8 + j % 4), k0 + 3 + 4 * j);
        wait_idle();

        // Round robin wrap: 6, then 7 and 0 together, then 0 and 5 together
        sync(); k0 = cyc;
        issue(1, 6, 1'b0, 4'd3, 8'h00, 1);
        expect_rd(1, 6, mem_init(3), k0 + 3);
        wait_idle();
        sync(); k0 = cyc;
        issue(1, 7, 1'b0, 4'd4, 8'h00, 1);
        issue(1, 0, 1'b0, 4'd1, 8'h00, 1);
        expect_rd(1, 7, mem_init(4), k0 + 3);
        expect_rd(1, 0, mem_init(1), k0 + 7);
        wait_idle();
        sync(); k0 = cyc;
        issue(1, 0, 1'b0, 4'd6, 8'h00, 1);
        issue(1, 5, 1'b0, 4'd9, 8'h00, 1);
        expect_rd(1, 5, mem_init(9), k0 + 3);
        expect_rd(1, 0, mem_init(6), k0 + 7);
        wait_idle();

        // Server acks on the last allowed BUSY cycle: normal completion
        wait_n[1] = TO - 1;
        sync(); k0 = cyc;
        issue(1, 2, 1'b0, 4'd10, 8'h00, 1);
        expect_rd(1, 2, mem_init(10), k0 + 17);
        wait_idle();

        // Server one cycle too slow
        wait_n[1] = TO;
        sync(); k0 = cyc;
        issue(1, 3, 1'b0, 4'd11, 8'h00, 1);
`ifdef ARB_TIMEOUT_EN
        expect_ack(1, 3, 8'h00, 1'b1, k0 + 17);
        exp_dr[1] = 8'h00;
`else
        expect_rd(1, 3, mem_init(11), k0 + 18);
`endif
        wait_idle();
        wait_n[1] = 1;

`ifdef ARB_TIMEOUT_EN
        // Server never acks
        mute[1] = 1'b1;
        sync(); k0 = cyc;
        issue(1, 4, 1'b0, 4'd13, 8'h00, 1);
        expect_ack(1, 4, 8'h00, 1'b1, k0 + 17);
        exp_dr[1] = 8'h00;
        wait_idle();
        check("wd_back_idle", 32'(gv[1]), 0);
        mute[1] = 1'b0;
`endif

        // Next request after a slow/aborted one is served normally
        sync(); k0 = cyc;
        issue(1, 5, 1'b0, 4'd12, 8'h00, 1);
        expect_rd(1, 5, mem_init(12), k0 + 3);
        wait_idle();

        // Reset asserted mid-BUSY
        mute[0] = 1'b1;
        sync(); k0 = cyc;
        issue(0, 2, 1'b0, 4'd3, 8'h00, 1);
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy_before", 32'(gv[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_server_rq", 32'(s_rq[0]), 0);
        check("midrst_ack", 32'(ack[0]), 0);
        check("midrst_grant_id", 32'(gid[0]), 0);
        check("midrst_grant_valid", 32'(gv[0]), 0);
        check("midrst_dataR", 32'(dr[0]), 0);
        @(negedge clk);
        reset     = 1'b0;
        mute[0]   = 1'b0;
        exp_dr[0] = 8'h00;
        exp_dr[1] = 8'h00;
        wait_idle();

        // After reset: strict lane serves normally, round-robin pointer restarts at client 0
        sync(); k0 = cyc;
        issue(0, 3, 1'b0, 4'd4, 8'h00, 1);
        expect_rd(0, 3, mem_init(4), k0 + 3);
        issue(1, 4, 1'b0, 4'd14, 8'h00, 1);
        issue(1, 6, 1'b0, 4'd15, 8'h00, 1);
        expect_rd(1, 4, mem_init(14), k0 + 3);
        expect_rd(1, 6, mem_init(15), k0 + 7);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
